// File: rtl/command_issue_queue.sv
// command_issue_queue
// Buffers 12-bit ALU commands in a circular queue and issues them one at a
// time to the ALU controller as a held `command` word plus a one-cycle
// `syscall` pulse. Issues are spaced ISSUE_GAP cycles apart so that every
// command is latched while the controller sits in IDLE.
// Optional feature macro: CMD_ISSUE_STATS_EN adds the `issued_count` and
// `stall_seen` statistics outputs.
module command_issue_queue #(
  parameter int DEPTH     = 8,  // power of two, >= 2
  parameter int ISSUE_GAP = 5   // >= 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              cmd_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     halt,
  output logic [11:0]              command,
  output logic                     syscall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef CMD_ISSUE_STATS_EN
  ,
  output logic [15:0]              issued_count,
  output logic                     stall_seen
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(ISSUE_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [11:0]     command_q, command_d;
  logic [11:0]     mem_q [DEPTH];

  logic push;
  logic pop;
  logic can_issue;

  // Handshake and issue qualifiers; cmd_ready depends on occupancy only.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign can_issue = (count_q != '0) && !halt;

  // Issue FSM: next state, gap counter and pop decision.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_HOLD;
        gap_d   = GAP_LOAD;
      end
      S_HOLD: begin
        if (gap_q == '0) begin
          // halt is only looked at here, so a running gap is never cut short
          if (can_issue) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, occupancy and command-register updates.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    command_d = pop  ? mem_q[rd_ptr_q]   : command_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q   <= S_IDLE;
      gap_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      command_q <= 12'h000;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      command_q <= command_d;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the occupancy counter and
    // pointers define which entries are valid, so stale data is never read.
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  assign syscall = (state_q == S_ISSUE);
  assign busy    = (state_q != S_IDLE);
  assign command = command_q;
  assign count   = count_q;

`ifdef CMD_ISSUE_STATS_EN
  logic [15:0] issued_count_q, issued_count_d;
  logic        stall_seen_q, stall_seen_d;

  // Statistics: issues counted on every pop edge (wraps), sticky stall flag.
  always_comb begin
    issued_count_d = pop ? issued_count_q + 16'd1 : issued_count_q;
    stall_seen_d   = stall_seen_q || (cmd_valid && !cmd_ready);
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_count_q <= '0;
      stall_seen_q   <= 1'b0;
    end else begin
      issued_count_q <= issued_count_d;
      stall_seen_q   <= stall_seen_d;
    end
  end

  assign issued_count = issued_count_q;
  assign stall_seen   = stall_seen_q;
`endif

endmodule

// File: tb/tb_command_issue_queue.sv
// Self-checking bench for command_issue_queue (DEPTH=8, ISSUE_GAP=5).
// Build with CMD_ISSUE_STATS_EN defined to also cover the statistics outputs.
module tb_command_issue_queue;

  localparam int DEPTH     = 8;
  localparam int ISSUE_GAP = 5;

  logic        clk;
  logic        rst_n;
  logic [11:0] cmd_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        halt;
  logic [11:0] command;
  logic        syscall;
  logic [3:0]  count;
  logic        busy;
`ifdef CMD_ISSUE_STATS_EN
  logic [15:0] issued_count;
  logic        stall_seen;
`endif

  command_issue_queue #(.DEPTH(DEPTH), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .halt      (halt),
    .command   (command),
    .syscall   (syscall),
    .count     (count),
    .busy      (busy)
`ifdef CMD_ISSUE_STATS_EN
    ,
    .issued_count (issued_count),
    .stall_seen   (stall_seen)
`endif
  );

  typedef struct {
    logic [11:0] cmd;
    int          exp_edge;  // syscall edge relative to first acceptance edge
  } burst_vec_t;

  typedef struct {
    logic [11:0] cmd;
    int          cyc;
  } obs_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [11:0] exp_q [$];   // scoreboard: commands expected to issue, in order
  obs_t        obs_q [$];   // every observed issue with its edge number
  logic        prev_sys = 1'b0;
  logic [11:0] last_cmd = 12'h000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted; scoreboard records it.
  task automatic push_word(input logic [11:0] w);
    int n = 0;
    cmd_in    = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check("push_timeout", (n < 500), 1);
    exp_q.push_back(w);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || count != 0) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_timeout", (n < 1000), 1);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_cmd = 12'h000;
    end else if (syscall) begin
      check("pulse_single", prev_sys, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_syscall: got command %0h expected no issue", command);
      end else begin
        check("cmd_order", command, exp_q.pop_front());
      end
      obs_q.push_back('{command, cyc});
      last_cmd = command;
    end else begin
      check("cmd_stable", command, last_cmd);
    end
    prev_sys = syscall;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    burst_vec_t burst [8];
    int start;

    burst[0] = '{12'h001,  1};
    burst[1] = '{12'h002,  6};
    burst[2] = '{12'h003, 11};
    burst[3] = '{12'h004, 16};
    burst[4] = '{12'h005, 21};
    burst[5] = '{12'h006, 26};
    burst[6] = '{12'h007, 31};
    burst[7] = '{12'h008, 36};

    rst_n     = 1'b0;
    cmd_in    = 12'h000;
    cmd_valid = 1'b0;
    halt      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_count",     count,     0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_syscall",   syscall,   0);
    check("rst_busy",      busy,      0);
    check("rst_command",   command,   12'h000);
    rst_n = 1'b1;
    tick();

    // Single push: pulse appears in the cycle after the edge following acceptance
    push_word(12'hE53);
    check("single_count_after_accept", count,   1);
    check("single_no_early_syscall",   syscall, 0);
    tick();
    check("single_syscall",   syscall, 1);
    check("single_command",   command, 12'hE53);
    check("single_busy",      busy,    1);
    tick();
    check("single_syscall_fall", syscall, 0);
    check("single_command_hold", command, 12'hE53);
    wait_idle();
    check("single_issue_count", obs_q.size(), 1);

    // Burst of 8: one issue every ISSUE_GAP cycles, in order
    obs_q.delete();
    start = cyc + 1;
    foreach (burst[k]) push_word(burst[k].cmd);
    wait_idle();
    check("burst_count_zero", count, 0);
    check("burst_issues", obs_q.size(), 8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      check("burst_cmd",    obs_q[k].cmd,         burst[k].cmd);
      check("burst_timing", obs_q[k].cyc - start, burst[k].exp_edge);
    end

    // Full: 8 accepted while halted, 9th held until space appears
    obs_q.delete();
    halt = 1'b1;
    for (int k = 0; k < 8; k++) push_word(12'h101 + 12'(k));
    check("full_count",     count,     8);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_no_issue",  busy,      0);
    cmd_in    = 12'h109;
    cmd_valid = 1'b1;
    repeat (3) tick();
    check("full_held_count", count, 8);
    halt = 1'b0;
    push_word(12'h109);
    wait_idle();
    check("full_issues", obs_q.size(), 9);
    for (int k = 0; k < 9 && k < obs_q.size(); k++)
      check("full_cmd", obs_q[k].cmd, 12'h101 + 12'(k));

    // Halt raised during HOLD: current gap completes, then nothing until release
    obs_q.delete();
    push_word(12'h201);
    push_word(12'h202);
    push_word(12'h203);
    halt = 1'b1;
    check("halt_in_hold_busy",    busy,    1);
    check("halt_in_hold_syscall", syscall, 0);
    repeat (20) tick();
    check("halt_issues",  obs_q.size(), 1);
    check("halt_busy",    busy,         0);
    check("halt_count",   count,        2);
    halt = 1'b0;
    wait_idle();
    check("halt_release_issues", obs_q.size(), 3);

    // Reset mid-HOLD with 3 entries queued
    obs_q.delete();
    push_word(12'h301);
    push_word(12'h302);
    push_word(12'h303);
    push_word(12'h304);
    check("pre_rst_count",   count,   3);
    check("pre_rst_busy",    busy,    1);
    check("pre_rst_syscall", syscall, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_syscall", syscall, 0);
    check("mid_rst_command", command, 12'h000);
    check("mid_rst_count",   count,   0);
    check("mid_rst_busy",    busy,    0);
    exp_q.delete();
    obs_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_rst_no_issue", obs_q.size(), 0);
    check("post_rst_count",    count,        0);
    check("post_rst_busy",     busy,         0);

`ifdef CMD_ISSUE_STATS_EN
    // Statistics: three issues, then a stalled push attempt
    push_word(12'h401);
    push_word(12'h402);
    push_word(12'h403);
    wait_idle();
    check("stats_issued_3", issued_count, 3);
    halt = 1'b1;
    for (int k = 0; k < 8; k++) push_word(12'h410 + 12'(k));
    check("stats_stall_clear", stall_seen, 0);
    cmd_in    = 12'h4FF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("stats_stall_set", stall_seen, 1);
    halt = 1'b0;
    wait_idle();
    check("stats_stall_sticky", stall_seen,   1);
    check("stats_issued_11",    issued_count, 11);
    rst_n = 1'b0;
    #1;
    check("stats_rst_issued", issued_count, 0);
    check("stats_rst_stall",  stall_seen,   0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
